// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and error-bit layout for the ALU sequencer.
// Pure definitions: no latency, no flow control.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_XOR  = 5'b01101;
    localparam logic [4:0] OP_NOR  = 5'b01110;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int ERR_ILLEGAL_BIT = 0;
    localparam int ERR_DIV_ZERO_BIT = 1;

    function automatic int max3(input int x, input int y, input int z);
        int m;
        m = (x > y) ? x : y;
        return (m > z) ? m : z;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Opcode classifier: legality, mul/div class and EXEC latency for that class.
// Purely combinational, zero latency, no flow control.
import alu_pkg::*;

module alu_op_decode #(
    parameter int SIMPLE_CYCLES = 1,
    parameter int MUL_CYCLES    = 4,
    parameter int DIV_CYCLES    = 8,
    parameter int CNT_W         = 4
) (
    input  logic [4:0]       opcode,
    output logic             legal,
    output logic             is_mul,
    output logic             is_div,
    output logic [CNT_W-1:0] latency
);

    always_comb begin
        legal  = 1'b0;
        is_mul = 1'b0;
        is_div = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_SHRA, OP_ROR, OP_ROL,
            OP_AND, OP_OR, OP_NEG, OP_XOR, OP_NOR, OP_NOT, OP_NOP: begin
                legal = 1'b1;
            end
            OP_MUL: begin
                legal  = 1'b1;
                is_mul = 1'b1;
            end
            OP_DIV: begin
                legal  = 1'b1;
                is_div = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase

        if (is_mul) begin
            latency = CNT_W'(MUL_CYCLES);
        end else if (is_div) begin
            latency = CNT_W'(DIV_CYCLES);
        end else begin
            latency = CNT_W'(SIMPLE_CYCLES);
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Single-issue ALU front end: latch op, hold ALU inputs for the class latency, return HI/LO.
// Legal op takes N+2 cycles, screened error 2; response held until rsp_ready, no new request meanwhile.
import alu_pkg::*;

module alu_op_sequencer #(
    parameter int SIMPLE_CYCLES = 1,
    parameter int MUL_CYCLES    = 4,
    parameter int DIV_CYCLES    = 8
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_opcode,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_opcode,
    input  logic [63:0] alu_c,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_hi,
    output logic [31:0] rsp_lo,
    output logic [1:0]  rsp_err,
    output logic        busy
);

    localparam int CNT_W = $clog2(max3(SIMPLE_CYCLES, MUL_CYCLES, DIV_CYCLES) + 1);

    state_e             state_q, state_d;
    logic [4:0]         opcode_q, opcode_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [1:0]         err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               dec_legal;
    logic               unused_dec_is_mul;
    logic               dec_is_div;
    logic [CNT_W-1:0]   dec_latency;

    // Screening looks at the incoming request so the IDLE edge can pick EXEC or DONE directly.
    alu_op_decode #(
        .SIMPLE_CYCLES (SIMPLE_CYCLES),
        .MUL_CYCLES    (MUL_CYCLES),
        .DIV_CYCLES    (DIV_CYCLES),
        .CNT_W         (CNT_W)
    ) u_decode (
        .opcode  (req_opcode),
        .legal   (dec_legal),
        .is_mul  (unused_dec_is_mul),
        .is_div  (dec_is_div),
        .latency (dec_latency)
    );

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        err_d    = err_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    opcode_d = req_opcode;
                    a_d      = req_a;
                    b_d      = req_b;
                    if (!dec_legal) begin
                        state_d = ST_DONE;
                        hi_d    = '0;
                        lo_d    = '0;
                        err_d   = '0;
                        err_d[ERR_ILLEGAL_BIT] = 1'b1;
                    end else if (dec_is_div && (req_a == '0)) begin
                        state_d = ST_DONE;
                        hi_d    = '0;
                        lo_d    = '0;
                        err_d   = '0;
                        err_d[ERR_DIV_ZERO_BIT] = 1'b1;
                    end else begin
                        state_d = ST_EXEC;
                        cnt_d   = dec_latency - 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    hi_d    = alu_c[63:32];
                    lo_d    = alu_c[31:0];
                    err_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            opcode_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            err_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // The ALU only sees the real opcode while EXEC holds it; otherwise it idles on nop.
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_opcode = (state_q == ST_EXEC) ? opcode_q : OP_NOP;

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_valid  = (state_q == ST_DONE);
    assign rsp_hi     = hi_q;
    assign rsp_lo     = lo_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer with a timing-aware ALU model and an op-level reference.
import alu_pkg::*;

module tb_alu_op_sequencer;

    localparam int SC = 1;
    localparam int MC = 4;
    localparam int DC = 8;

    logic        clock = 1'b0;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_opcode;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_opcode;
    logic [63:0] alu_c;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_hi;
    logic [31:0] rsp_lo;
    logic [1:0]  rsp_err;
    logic        busy;

    always #5 clock = ~clock;

    alu_op_sequencer #(
        .SIMPLE_CYCLES (SC),
        .MUL_CYCLES    (MC),
        .DIV_CYCLES    (DC)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_c      (alu_c),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_hi     (rsp_hi),
        .rsp_lo     (rsp_lo),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [4:0] legal_ops [16] = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SHR, OP_SHL, OP_SHRA, OP_ROR,
                                  OP_ROL, OP_AND, OP_OR, OP_NEG, OP_XOR, OP_NOR, OP_NOT, OP_NOP};

    function automatic bit is_legal(input logic [4:0] op);
        for (int i = 0; i < 16; i++) begin
            if (legal_ops[i] == op) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int lat_of(input logic [4:0] op);
        if (op == OP_MUL) return MC;
        if (op == OP_DIV) return DC;
        return SC;
    endfunction

    function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa;
        logic [63:0] sb;
        logic [5:0]  sh;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        sh = {1'b0, b[4:0]};
        case (op)
            OP_ADD:  return sa + sb;
            OP_SUB:  return sa - sb;
            OP_MUL:  return sa * sb;
            OP_DIV:  return (a == 32'd0) ? 64'd0 : {b % a, b / a};
            OP_SHR:  return {32'd0, a >> sh};
            OP_SHL:  return {32'd0, a << sh};
            OP_SHRA: return {32'd0, $unsigned($signed(a) >>> sh)};
            OP_ROR:  return {32'd0, (a >> sh) | (a << (6'd32 - sh))};
            OP_ROL:  return {32'd0, (a << sh) | (a >> (6'd32 - sh))};
            OP_AND:  return {32'd0, a & b};
            OP_OR:   return {32'd0, a | b};
            OP_NEG:  return 64'd0 - sa;
            OP_XOR:  return {32'd0, a ^ b};
            OP_NOR:  return {32'd0, ~(a | b)};
            OP_NOT:  return {32'd0, ~a};
            OP_NOP:  return {a, b};
            default: return 64'h0BAD_0BAD_0BAD_0BAD;
        endcase
    endfunction

    // ALU model: result is only correct once its inputs have been steady for the class latency.
    logic [68:0] alu_in;
    logic [68:0] snap = '1;
    int          held = 0;
    int          run_len;

    assign alu_in = {alu_opcode, alu_a, alu_b};

    always @(posedge clock) begin
        if (alu_in == snap) begin
            held <= held + 1;
        end else begin
            snap <= alu_in;
            held <= 1;
        end
    end

    always_comb begin
        run_len = (alu_in == snap) ? held + 1 : 1;
        alu_c   = (run_len >= lat_of(alu_opcode)) ? alu_fn(alu_opcode, alu_a, alu_b)
                                                   : 64'hDEAD_BEEF_DEAD_BEEF;
    end

    logic [31:0] last_hi;
    logic [31:0] last_lo;
    logic [1:0]  last_err;

    // Issue one op at a negedge; stall the response for 'stall' cycles, optionally poking req_valid.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int stall, input bit poke);
        logic [1:0]  e_err;
        logic [63:0] e_res;
        int          e_lat;
        int          n;
        if (!is_legal(op))                       e_err = 2'b01;
        else if (op == OP_DIV && a == 32'd0)     e_err = 2'b10;
        else                                     e_err = 2'b00;
        e_res = (e_err == 2'b00) ? alu_fn(op, a, b) : 64'd0;
        e_lat = (e_err == 2'b00) ? lat_of(op) : 0;

        check("idle_req_ready", 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_opcode = op;
        req_a      = a;
        req_b      = b;
        @(negedge clock);
        req_valid  = 1'b0;
        req_opcode = 5'($urandom);
        req_a      = $urandom;
        req_b      = $urandom;

        n = 0;
        while (!rsp_valid && n < 40) begin
            check("exec_opcode", 64'(alu_opcode), 64'(op));
            check("exec_a", 64'(alu_a), 64'(a));
            check("exec_b", 64'(alu_b), 64'(b));
            check("exec_req_ready", 64'(req_ready), 64'd0);
            @(negedge clock);
            n++;
        end
        check("rsp_latency", 64'(n), 64'(e_lat));
        check("rsp_hi", 64'(rsp_hi), 64'(e_res[63:32]));
        check("rsp_lo", 64'(rsp_lo), 64'(e_res[31:0]));
        check("rsp_err", 64'(rsp_err), 64'(e_err));
        check("done_opcode_nop", 64'(alu_opcode), 64'(OP_NOP));
        check("done_req_ready", 64'(req_ready), 64'd0);
        check("done_busy", 64'(busy), 64'd1);
        last_hi  = rsp_hi;
        last_lo  = rsp_lo;
        last_err = rsp_err;

        for (int s = 0; s < stall; s++) begin
            req_valid  = poke && (s == 0);
            req_opcode = OP_ADD;
            @(negedge clock);
            req_valid = 1'b0;
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_hi", 64'(rsp_hi), 64'(e_res[63:32]));
            check("hold_lo", 64'(rsp_lo), 64'(e_res[31:0]));
            check("hold_err", 64'(rsp_err), 64'(e_err));
            check("hold_req_ready", 64'(req_ready), 64'd0);
        end

        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        check("ret_rsp_valid", 64'(rsp_valid), 64'd0);
        check("ret_req_ready", 64'(req_ready), 64'd1);
        check("ret_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        clear      = 1'b1;
        req_valid  = 1'b0;
        req_opcode = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b0;
        repeat (3) @(negedge clock);
        clear = 1'b0;

        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_alu_opcode", 64'(alu_opcode), 64'(5'b11010));
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_alu_b", 64'(alu_b), 64'd0);
        check("rst_hi", 64'(rsp_hi), 64'd0);
        check("rst_lo", 64'(rsp_lo), 64'd0);
        check("rst_err", 64'(rsp_err), 64'd0);

        run_op(OP_ADD, 32'd5, 32'd7, 0, 1'b0);
        check("add_hi", 64'(last_hi), 64'd0);
        check("add_lo", 64'(last_lo), 64'd12);
        check("add_err", 64'(last_err), 64'd0);

        run_op(OP_SUB, 32'd3, 32'd5, 0, 1'b0);
        check("sub_hi", 64'(last_hi), 64'hFFFF_FFFF);
        check("sub_lo", 64'(last_lo), 64'hFFFF_FFFE);

        run_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, 0, 1'b0);
        check("mul_hi", 64'(last_hi), 64'd1);
        check("mul_lo", 64'(last_lo), 64'd0);

        run_op(OP_DIV, 32'd0, 32'd123, 0, 1'b0);
        check("divz_err", 64'(last_err), 64'd2);
        check("divz_hi", 64'(last_hi), 64'd0);
        check("divz_lo", 64'(last_lo), 64'd0);

        run_op(5'b11111, 32'd9, 32'd9, 0, 1'b0);
        check("illegal_err", 64'(last_err), 64'd1);

        run_op(OP_ADD, 32'd100, 32'd23, 3, 1'b1);
        check("bp_lo", 64'(last_lo), 64'd123);

        // Leave nonzero results behind, then abort a mul in its second EXEC cycle.
        run_op(OP_SUB, 32'd3, 32'd5, 0, 1'b0);
        req_valid  = 1'b1;
        req_opcode = OP_MUL;
        req_a      = 32'h0001_0000;
        req_b      = 32'h0001_0000;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        check("clr_pre_busy", 64'(busy), 64'd1);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_req_ready", 64'(req_ready), 64'd1);
        check("clr_alu_opcode", 64'(alu_opcode), 64'(OP_NOP));
        check("clr_hi", 64'(rsp_hi), 64'd0);
        check("clr_lo", 64'(rsp_lo), 64'd0);
        check("clr_alu_a", 64'(alu_a), 64'd0);
        for (int i = 0; i < 8; i++) begin
            check("clr_no_rsp", 64'(rsp_valid), 64'd0);
            @(negedge clock);
        end

        for (int i = 0; i < 80; i++) begin
            op = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 15)] : 5'($urandom);
            a  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            b  = $urandom;
            run_op(op, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
